// File: rtl/sram_access_controller_if.sv
// Pipeline-side request/response bundle for the SRAM access controller.
// master = EXE/MEM side issuing loads/stores, slave = controller.
interface sram_access_controller_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        freeze;

  modport master (
    output mem_r_en, mem_w_en, address, write_data,
    input  read_data, ready, freeze
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, write_data,
    output read_data, ready, freeze
  );
endinterface

// File: rtl/sram_access_controller.sv
// 32-bit load/store sequencer onto a 16-bit SRAM, low half then high half.
// Define SRAM_ADDR_OFFSET_EN to rebase data memory from byte 0x400 to SRAM 0.
module sram_access_controller #(
  parameter int PHASE_CYCLES = 2,
  parameter int ADDR_W       = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  sram_access_controller_if.slave    bus,
  output logic [ADDR_W-1:0]          sram_addr,
  inout  wire  [15:0]                sram_dq,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [1:0] LAST = 2'(PHASE_CYCLES - 1);

  state_t            state, state_n;
  logic [1:0]        cnt, cnt_n;
  logic              is_wr;
  logic [ADDR_W-2:0] waddr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [31:0]       eff;
  logic              req;
  logic              drive;
  logic [15:0]       dq_out;
  logic              unused_addr;

`ifdef SRAM_ADDR_OFFSET_EN
  assign eff = bus.address - 32'd1024;
`else
  assign eff = bus.address;
`endif

  assign unused_addr = ^{eff[31:ADDR_W+1], eff[1:0]};

  assign req           = bus.mem_r_en | bus.mem_w_en;
  assign bus.read_data = rdata;
  assign sram_dq       = drive ? dq_out : 16'hzzzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      is_wr <= 1'b0;
      waddr <= '0;
      wdata <= 32'd0;
      rdata <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && req) begin
        is_wr <= bus.mem_w_en;
        waddr <= eff[ADDR_W:2];
        wdata <= bus.write_data;
      end
      // Sample the bus on the last cycle of each read phase
      if (!is_wr && cnt == LAST) begin
        if (state == LO) rdata[15:0]  <= sram_dq;
        if (state == HI) rdata[31:16] <= sram_dq;
      end
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bus.freeze = 1'b0;
    bus.ready  = 1'b0;
    sram_addr  = '0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    drive      = 1'b0;
    dq_out     = 16'd0;
    unique case (state)
      IDLE: begin
        bus.freeze = req;
        if (req) begin
          state_n = LO;
          cnt_n   = 2'd0;
        end
      end
      LO, HI: begin
        bus.freeze = 1'b1;
        sram_addr  = {waddr, state == HI};
        if (is_wr) begin
          sram_we_n = 1'b0;
          drive     = 1'b1;
          dq_out    = (state == HI) ? wdata[31:16] : wdata[15:0];
        end else begin
          sram_oe_n = 1'b0;
        end
        if (cnt == LAST) begin
          state_n = (state == HI) ? DONE : HI;
          cnt_n   = 2'd0;
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      DONE: begin
        bus.ready = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_access_controller.sv
// Scoreboard bench for sram_access_controller with a behavioural SRAM.
// Works with or without SRAM_ADDR_OFFSET_EN defined.
module tb_sram_access_controller;

`ifdef SRAM_ADDR_OFFSET_EN
  localparam logic [17:0] OFS = 18'h000;
`else
  localparam logic [17:0] OFS = 18'h200;
`endif

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic [15:0] sram_mem [0:(1<<18)-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  resp_t rq[$];
  wr_t   wq[$];

  sram_access_controller_if bus ();

  sram_access_controller #(
    .PHASE_CYCLES(2),
    .ADDR_W(18)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sram_addr(sram_addr),
    .sram_dq  (sram_dq),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq = sram_oe_n ? 16'hzzzz : sram_mem[sram_addr];

  always @(posedge clk)
    if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response
  always @(negedge clk) begin
    if (!rst) begin
      if (!sram_we_n && !sram_oe_n)
        check("we_oe_overlap", 32'd1, 32'd0);
      if (!sram_we_n) begin
        if (wq.size() == 0) begin
          check("unexpected_write", {14'd0, sram_addr}, 32'hffffffff);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_addr", {14'd0, sram_addr}, {14'd0, w.addr});
          check("wr_data", {16'd0, sram_dq}, {16'd0, w.data});
        end
      end
      if (bus.ready) begin
        if (rq.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          resp_t r;
          r = rq.pop_front();
          check("latency", cyc - r.cyc, 32'd5);
          if (r.rd) check("read_data", bus.read_data, r.data);
        end
      end
    end
  end

  task automatic push_write(input logic [17:0] ha, input logic [31:0] d);
    for (int p = 0; p < 2; p++) wq.push_back('{ha, d[15:0]});
    for (int p = 0; p < 2; p++) wq.push_back('{ha + 18'd1, d[31:16]});
  endtask

  task automatic access(input bit r_en, input bit w_en,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [17:0] ha, input logic [31:0] exp_rd);
    bit wr;
    wr = w_en;
    @(negedge clk);
    bus.mem_r_en   = r_en;
    bus.mem_w_en   = w_en;
    bus.address    = a;
    bus.write_data = d;
    rq.push_back('{!wr, exp_rd, cyc});
    if (wr) push_write(ha, d);
    #1 check("freeze_c0", {31'd0, bus.freeze}, 32'd1);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
      end
      #1;
      check("freeze", {31'd0, bus.freeze}, {31'd0, k < 5});
      check("oe_n", {31'd0, sram_oe_n}, {31'd0, wr || k > 4});
      check("we_n", {31'd0, sram_we_n}, {31'd0, !wr || k > 4});
    end
  endtask

  initial begin
    bus.mem_r_en   = 1'b0;
    bus.mem_w_en   = 1'b0;
    bus.address    = 32'd0;
    bus.write_data = 32'd0;
    for (int i = 0; i < (1 << 18); i++) sram_mem[i] = 16'd0;
    sram_mem[OFS + 18'h100] = 16'h5678;
    sram_mem[OFS + 18'h101] = 16'h1234;
    sram_mem[OFS + 18'h102] = 16'hcafe;
    sram_mem[OFS + 18'h103] = 16'hf00d;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_freeze", {31'd0, bus.freeze}, 32'd0);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_rdata", bus.read_data, 32'd0);

    access(1'b0, 1'b1, 32'h0000040c, 32'hdeadbeef, OFS + 18'h006, 32'd0);
    check("rdata_after_wr", bus.read_data, 32'd0);
    access(1'b1, 1'b0, 32'h0000040c, 32'd0, OFS + 18'h006, 32'hdeadbeef);
    access(1'b0, 1'b1, 32'h00000400, 32'h11112222, OFS, 32'd0);
    access(1'b1, 1'b1, 32'h00000412, 32'ha5a55a5a, OFS + 18'h008, 32'd0);
    check("mem_lo", {16'd0, sram_mem[OFS + 18'h008]}, 32'h00005a5a);
    check("mem_hi", {16'd0, sram_mem[OFS + 18'h009]}, 32'h0000a5a5);
    access(1'b1, 1'b0, 32'h00000410, 32'd0, OFS + 18'h008, 32'ha5a55a5a);
    access(1'b1, 1'b0, 32'h00000400, 32'd0, OFS, 32'h11112222);

    // Back-to-back loads with the request held across DONE
    @(negedge clk);
    bus.mem_r_en = 1'b1;
    bus.address  = 32'h00000600;
    rq.push_back('{1'b1, 32'h12345678, cyc});
    rq.push_back('{1'b1, 32'hf00dcafe, cyc + 6});
    #1 check("b2b_freeze0", {31'd0, bus.freeze}, 32'd1);
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      if (k == 5) bus.address = 32'h00000604;
      if (k == 7) bus.mem_r_en = 1'b0;
      #1 check("b2b_freeze", {31'd0, bus.freeze}, {31'd0, k != 5 && k != 11});
    end
    @(negedge clk);
    #1 check("b2b_idle", {31'd0, bus.freeze}, 32'd0);

    // Reset asserted in the middle of a write's low phase
    @(negedge clk);
    bus.mem_w_en   = 1'b1;
    bus.address    = 32'h00000420;
    bus.write_data = 32'h0bad0bad;
    wq.push_back('{OFS + 18'h010, 16'h0bad});
    @(negedge clk);
    bus.mem_w_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("abort_ready", {31'd0, bus.ready}, 32'd0);
    check("abort_freeze", {31'd0, bus.freeze}, 32'd0);
    check("abort_rdata", bus.read_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_write", {16'd0, sram_mem[OFS + 18'h010]}, 32'd0);

    check("resp_queue_empty", rq.size(), 32'd0);
    check("write_queue_empty", wq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
